// File: rtl/uart_tx_periph_if.sv
// CPU data-memory bus as seen by the UART transmitter peripheral.
interface uart_tx_periph_if;
  logic        MemRead;
  logic        MemWrite;
  logic [31:0] MemBus_Address;
  logic [31:0] MemBus_Write_Data;
  logic [31:0] Device_Read_Data;

  modport master (
    output MemRead, MemWrite, MemBus_Address, MemBus_Write_Data,
    input  Device_Read_Data
  );

  modport slave (
    input  MemRead, MemWrite, MemBus_Address, MemBus_Write_Data,
    output Device_Read_Data
  );
endinterface

// File: rtl/uart_tx_periph.sv
// Memory-mapped 8N1 UART transmitter with a small byte FIFO.
// Registers: TXDATA @BASE_ADDR, STATUS @+8, CONTROL @+12.
// Optional feature macro: UART_TX_IRQ_EN (transmit-done interrupt, CONTROL reg).
module uart_tx_periph #(
  parameter logic [31:0] BASE_ADDR = 32'h4000_0018,
  parameter logic [15:0] DIV       = 16'd5208,
  parameter int          DEPTH     = 4
) (
  input  logic             sysclk,
  input  logic             reset,
  uart_tx_periph_if.slave  bus,
  output logic             uart_txd,
  output logic             tx_irq
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  // STATUS register layout, LSB last
  typedef struct packed {
    logic [4:0] cnt;
    logic       ovf;
    logic       empty;
    logic       full;
    logic       busy;
  } stat_t;

  // address decode
  logic sel_tx, sel_st, sel_ctl;
  assign sel_tx  = (bus.MemBus_Address == BASE_ADDR);
  assign sel_st  = (bus.MemBus_Address == BASE_ADDR + 32'd8);
  assign sel_ctl = (bus.MemBus_Address == BASE_ADDR + 32'd12);

  // FIFO
  logic [7:0]    mem [DEPTH];
  logic [PW-1:0] wptr, rptr;
  logic [CW-1:0] count;
  logic          full, empty, push_req, push_ok, pop, ovf_set, ovf;

  assign full     = (count == CW'(DEPTH));
  assign empty    = (count == '0);
  assign push_req = bus.MemWrite & sel_tx;
  // a push into a full FIFO is fine when the head leaves on the same edge
  assign push_ok  = push_req & (~full | pop);
  assign ovf_set  = push_req & full & ~pop;

  // FIFO storage; head is read combinationally by the FSM on pop
  always_ff @(posedge sysclk) begin
    if (push_ok) mem[wptr] <= bus.MemBus_Write_Data[7:0];
  end

  // FIFO pointers, occupancy and sticky overflow
  always_ff @(posedge sysclk or negedge reset) begin
    if (!reset) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
      ovf   <= 1'b0;
    end else begin
      if (push_ok) wptr <= wptr + PW'(1);
      if (pop)     rptr <= rptr + PW'(1);
      count <= count + CW'(push_ok) - CW'(pop);
      if (ovf_set)                  ovf <= 1'b1;
      else if (bus.MemRead & sel_st) ovf <= 1'b0;
    end
  end

  // transmit FSM
  state_t      state_q, state_d;
  logic [15:0] baud_q, baud_d;
  logic [2:0]  bit_q, bit_d;
  logic [7:0]  shr_q, shr_d;
  logic        txd_d, bit_end;

  assign bit_end = (baud_q == DIV - 16'd1);

  // FSM state, baud counter, shifter and registered line output
  always_ff @(posedge sysclk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      baud_q   <= '0;
      bit_q    <= '0;
      shr_q    <= '0;
      uart_txd <= 1'b1;
    end else begin
      state_q  <= state_d;
      baud_q   <= baud_d;
      bit_q    <= bit_d;
      shr_q    <= shr_d;
      uart_txd <= txd_d;
    end
  end

  // next-state, pop and next line level; every state change lands on bit_end,
  // so the baud counter is naturally reloaded to 0 on entry
  always_comb begin
    state_d = state_q;
    baud_d  = bit_end ? '0 : baud_q + 16'd1;
    bit_d   = bit_q;
    shr_d   = shr_q;
    pop     = 1'b0;
    case (state_q)
      IDLE: begin
        baud_d = '0;
        if (!empty) begin
          pop     = 1'b1;
          shr_d   = mem[rptr];
          state_d = START;
        end
      end
      START: if (bit_end) begin
        state_d = DATA;
        bit_d   = '0;
      end
      DATA: if (bit_end) begin
        if (bit_q == 3'd7) state_d = STOP;
        else               bit_d   = bit_q + 3'd1;
      end
      STOP: if (bit_end) begin
        if (!empty) begin
          pop     = 1'b1;
          shr_d   = mem[rptr];
          state_d = START;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    case (state_d)
      START:   txd_d = 1'b0;
      DATA:    txd_d = shr_d[bit_d];
      default: txd_d = 1'b1;
    endcase
  end

  // interrupt block
  logic [31:0] ctl_rd;
`ifdef UART_TX_IRQ_EN
  logic irq_en, irq_flag, irq_set, ctl_wr;
  assign irq_set = (state_q == STOP) & bit_end & empty;
  assign ctl_wr  = bus.MemWrite & sel_ctl;
  assign ctl_rd  = {29'd0, irq_flag, 1'b0, irq_en};

  // enable, sticky done flag (set beats clear), registered request
  always_ff @(posedge sysclk or negedge reset) begin
    if (!reset) begin
      irq_en   <= 1'b0;
      irq_flag <= 1'b0;
      tx_irq   <= 1'b0;
    end else begin
      if (ctl_wr) irq_en <= bus.MemBus_Write_Data[0];
      if (irq_set)                               irq_flag <= 1'b1;
      else if (ctl_wr & bus.MemBus_Write_Data[1]) irq_flag <= 1'b0;
      tx_irq <= irq_flag & irq_en;
    end
  end
`else
  assign ctl_rd = '0;
  assign tx_irq = 1'b0;
`endif

  // zero-wait read mux
  stat_t       st;
  logic [31:0] rdata;
  assign st = '{cnt: 5'(count), ovf: ovf, empty: empty, full: full,
                busy: (state_q != IDLE)};

  // read data is zero unless a mapped readable register is being read
  always_comb begin
    rdata = '0;
    if (bus.MemRead) begin
      if (sel_st)       rdata = {23'd0, st};
      else if (sel_ctl) rdata = ctl_rd;
    end
  end
  assign bus.Device_Read_Data = rdata;

endmodule

// File: doc/uart_tx_periph.md
# uart_tx_periph

Memory-mapped UART transmitter on the CPU's data-memory bus, downstream of the pipeline's MEM stage. It decodes the CPU's MemRead/MemWrite/MemBus_Address, buffers written bytes in a small FIFO and serialises them as 8N1 frames on `uart_txd`. It returns status to the CPU through `Device_Read_Data` and optionally raises a transmit-done interrupt.

## Interface
- `BASE_ADDR`, default 32'h4000_0018: byte address of the TXDATA register. STATUS is at +8 and CONTROL at +12.
- `DIV`, default 16'd5208: sysclk cycles per UART bit. Must be ≥ 2.
- `DEPTH`, default 4: FIFO entries. Must be a power of two, 2..16.
- `sysclk` in 1: system clock. All state changes on the rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `MemRead` in 1: CPU read strobe.
- `MemWrite` in 1: CPU write strobe, sampled on the rising edge.
- `MemBus_Address` in 32: byte address.
- `MemBus_Write_Data` in 32: write data. Only bits [7:0] or the low control bits are used.
- `Device_Read_Data` out 32: read data. Combinational, zero wait.
- `uart_txd` out 1: serial line. Idles high.
- `tx_irq` out 1: interrupt request, active high.

## Operation
- **Register map**
  - TXDATA (write-only): pushes `MemBus_Write_Data[7:0]`. Reads return 0.
  - STATUS (read-only):
    - bit0 busy (FSM not IDLE)
    - bit1 full
    - bit2 empty
    - bit3 overflow (sticky)
    - bits[8:4] count
    - other bits 0
  - CONTROL:
    - bit0 irq_en (R/W)
    - bit1 write-1-clears irq_flag
    - bit2 reads irq_flag
- **Unmapped addresses:** `Device_Read_Data` = 0. Writes are ignored.
- **Read data:** when `MemRead` = 0, `Device_Read_Data` = 0.
- **Push rules**
  - A push is accepted when not full.
  - A push is also accepted when full if a pop occurs in the same cycle; count stays DEPTH.
  - Any other push while full is dropped and sets overflow.
- **Overflow clear:** overflow clears on the rising edge ending a STATUS read with `MemRead` = 1. If a set and a clear occur in the same cycle, set wins.
- **FSM states:** IDLE, START, DATA, STOP.
  - IDLE: `uart_txd` = 1. If FIFO is non-empty, pop the head into the shift register and go to START.
  - START: `uart_txd` = 0 for DIV cycles, then go to DATA.
  - DATA: 8 bits, LSB first, DIV cycles each. A bit index 0..7 selects the bit; go to STOP after bit 7.
  - STOP: `uart_txd` = 1 for DIV cycles. At the end:
    - FIFO non-empty: pop and go directly to START (no idle gap).
    - FIFO empty: go to IDLE and set irq_flag.
- **Interrupt:** `tx_irq` = irq_flag & irq_en, registered.
  - irq_flag set and a CONTROL clear in the same cycle: set wins.
- **Baud counter:** counts 0..DIV-1 and wraps. It reloads at every state entry.
- **FIFO pointers:** log2(DEPTH) bits and wrap naturally. Count is log2(DEPTH)+1 bits.

## Timing
- **Reset values:** `uart_txd` = 1, `tx_irq` = 0, `Device_Read_Data` = 0 (no read). FIFO is empty; count, overflow, irq_en and irq_flag are 0; FSM is in IDLE.
- **Reset mid-frame:** all state returns to the reset values asynchronously and `uart_txd` goes high immediately. Bytes in flight are lost.
- **First frame latency:** write to an empty FIFO while IDLE at edge k.
  - Count = 1 after edge k.
  - At edge k+1 the byte is popped and `uart_txd` falls (START).
- **Frame length:** exactly 10·DIV cycles. Back-to-back frames are contiguous.
- **Interrupt latency:** irq_flag is set at the edge ending STOP. `tx_irq` rises one edge later.
- **STATUS visibility:** STATUS reflects the registered state before the current edge. A push at edge k is visible in a read during cycle k+1.

## Configuration
- **`UART_TX_IRQ_EN` defined:** irq_en, irq_flag and `tx_irq` logic are present as described.
- **`UART_TX_IRQ_EN` undefined:**
  - `tx_irq` is tied to 0.
  - CONTROL reads 0 and writes to it are ignored.
  - No interrupt flops are synthesised.
  - All other behaviour is unchanged.

## Test plan
- **Single byte:** bench uses DIV=4. Write 0xA5 to TXDATA.
  - `uart_txd` falls one cycle after the write edge.
  - Line sequence is 0,1,0,1,0,0,1,0,1,1, each held 4 cycles.
  - STATUS reads busy=1 during the frame, then 0x004 (empty).
- **Burst with overflow:** DEPTH=4, DIV=4, line IDLE. Write 0x11..0x16 on consecutive cycles.
  - The first byte pops immediately, so 0x11..0x15 are accepted and 0x16 is dropped.
  - STATUS reads overflow=1 and count=4; a second STATUS read shows overflow=0.
  - Five contiguous frames span 200 cycles.
- **Push-while-full-with-pop:** fill the FIFO and time a write to the cycle the STOP state ends.
  - Write is accepted, count stays 4, overflow stays 0.
- **Interrupt:** write CONTROL=1, then send 0x3C.
  - `tx_irq` rises 1 cycle after the STOP edge.
  - Writing CONTROL=0x3 clears it next edge.
  - CONTROL bit2 reads 0 afterwards.
  - With the macro undefined, `tx_irq` stays 0 throughout.
- **Reset mid-frame:** assert `reset` low during DATA bit 3.
  - `uart_txd` goes 1 immediately; STATUS reads 0x004 after release.
  - A fresh write transmits correctly.
- **Decode:** read an unmapped address and TXDATA, each with `MemRead`=1.
  - Both return 0x0.
  - A write to BASE_ADDR+4 leaves count at 0.
